// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and constants for the multi-cycle RV32I sequencer.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StHalt,
        StTrap
    } state_e;

    typedef enum logic [1:0] {
        CauseNone        = 2'd0,
        CauseIllegal     = 2'd1,
        CauseImemTimeout = 2'd2,
        CauseDmemTimeout = 2'd3
    } trap_cause_e;

    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcSystem = 7'b1110011;

    // ECALL/EBREAK live under SYSTEM with funct3 == 0
    localparam logic [2:0] Funct3Priv = 3'b000;

    localparam logic [31:0] InstrNop = 32'h0000_0013;

    // Opcodes that proceed through EXEC
    function automatic logic opc_is_exec(input logic [6:0] opc);
        case (opc)
            OpcLui, OpcAuipc, OpcJal, OpcJalr, OpcBranch,
            OpcLoad, OpcStore, OpcOpImm, OpcOp: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    function automatic logic opc_is_mem(input logic [6:0] opc);
        return (opc == OpcLoad) || (opc == OpcStore);
    endfunction

    function automatic logic opc_writes_rd(input logic [6:0] opc);
        return (opc != OpcBranch) && (opc != OpcStore);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Instruction/data memory handshake bundle between the sequencer and memory.
interface multicycle_ctrl_if;

    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        imem_req;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ready;

    modport master (
        output imem_req,
        output dmem_req,
        output dmem_we,
        input  imem_rdata,
        input  imem_ready,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  dmem_we,
        output imem_rdata,
        output imem_ready,
        output dmem_ready
    );

endinterface

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Wait-cycle counter shared by FETCH and MEM; flags a timeout when the
// request has waited MEM_TIMEOUT cycles and ready is still low.
module multicycle_ctrl_mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic ready,
    output logic expired
);

    localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WaitW-1:0] WaitMax = WaitW'(MEM_TIMEOUT);

    logic [WaitW-1:0] cnt_q, cnt_d;

    // Idle states hold the counter at zero, so every entry to a waiting
    // state starts from a clean count.
    always_comb begin
        cnt_d = cnt_q;
        if (!active) begin
            cnt_d = '0;
        end else if (!ready && (cnt_q != WaitMax)) begin
            cnt_d = cnt_q + WaitW'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Ready in the same cycle as the limit wins over the timeout
    always_comb begin
        expired = active && !ready && (cnt_q == WaitMax);
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: owns PC and IR, steps each instruction
// through FETCH/DECODE/EXEC/MEM/WB, and halts or traps terminally.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_ctrl_if.master    mem,
    input  logic [31:0]          pc_in,
    output logic [31:0]          pc,
    output logic [31:0]          ir,
    output logic                 rf_we,
    output logic                 halted,
    output logic                 trap,
    output logic [1:0]           trap_cause,
    output logic [CNT_W-1:0]     cycle_cnt,
    output logic [CNT_W-1:0]     instret_cnt
);

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      ir_q, ir_d;
    trap_cause_e      cause_q, cause_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       waiting;
    logic       wait_ready;
    logic       expired;

    assign opcode = ir_q[6:0];
    assign funct3 = ir_q[14:12];

    // One timer serves both waiting states; pick the matching ready
    assign waiting    = (state_q == StFetch) || (state_q == StMem);
    assign wait_ready = (state_q == StFetch) ? mem.imem_ready : mem.dmem_ready;

    multicycle_ctrl_mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .active (waiting),
        .ready  (wait_ready),
        .expired(expired)
    );

    // Next-state, PC/IR and counter updates
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        cause_d   = cause_q;
        cycle_d   = cycle_q;
        instret_d = instret_q;

        if ((state_q != StHalt) && (state_q != StTrap)) begin
            cycle_d = cycle_q + CNT_W'(1);
        end

        unique case (state_q)
            StFetch: begin
                if (mem.imem_ready) begin
                    ir_d    = mem.imem_rdata;
                    state_d = StDecode;
                end else if (expired) begin
                    cause_d = CauseImemTimeout;
                    state_d = StTrap;
                end
            end
            StDecode: begin
                if (opc_is_exec(opcode)) begin
                    state_d = StExec;
                end else if ((opcode == OpcSystem) && (funct3 == Funct3Priv)) begin
                    state_d = StHalt;
                end else begin
                    cause_d = CauseIllegal;
                    state_d = StTrap;
                end
            end
            StExec: begin
                state_d = opc_is_mem(opcode) ? StMem : StWb;
            end
            StMem: begin
                if (mem.dmem_ready) begin
                    state_d = StWb;
                end else if (expired) begin
                    cause_d = CauseDmemTimeout;
                    state_d = StTrap;
                end
            end
            StWb: begin
                // ir is unchanged since FETCH, so pc_in is stable here
                pc_d      = pc_in;
                instret_d = instret_q + CNT_W'(1);
                state_d   = StFetch;
            end
            StHalt, StTrap: begin
                state_d = state_q;
            end
            default: begin
                state_d = StTrap;
            end
        endcase
    end

    // Architectural state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StFetch;
            pc_q      <= RESET_PC;
            ir_q      <= InstrNop;
            cause_q   <= CauseNone;
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            cause_q   <= cause_d;
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    // Strobe and status decode from the current state
    always_comb begin
        mem.imem_req = (state_q == StFetch);
        mem.dmem_req = (state_q == StMem);
        mem.dmem_we  = (state_q == StMem) && (opcode == OpcStore);
        rf_we        = (state_q == StWb) && opc_writes_rd(opcode);
        halted       = (state_q == StHalt);
        trap         = (state_q == StTrap);
    end

    assign pc          = pc_q;
    assign ir          = ir_q;
    assign trap_cause  = cause_q;
    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;

endmodule
